// File: rtl/rect_reader_pkg.sv
// Shared constants and FSM encoding for the rectangle reader.
package rect_reader_pkg;
    localparam int COORD_W      = 8;
    localparam int COLOR_W_DEF  = 3;
    localparam int BG_COLOR_DEF = 0;

    typedef enum logic [1:0] {
        IDLE,
        EMPTY,
        SCAN,
        DRAIN
    } state_e;
endpackage

// File: rtl/rect_reader_if.sv
// Request, framebuffer-read and pixel-stream signals of the rectangle reader.
interface rect_reader_if
    import rect_reader_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF
) ();
    logic               start;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [COLOR_W-1:0] rd_data;
    logic               pix_valid;
    logic               pix_ready;
    logic [COLOR_W-1:0] pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_last;
    logic               busy;
    logic               done;
    logic               hit;

    modport slave (
        input  start, start_x, start_y, width, height, rd_data, pix_ready,
        output rd_en, rd_x, rd_y, pix_valid, pix_data, pix_x, pix_y, pix_last,
               busy, done, hit
    );

    modport master (
        output start, start_x, start_y, width, height, rd_data, pix_ready,
        input  rd_en, rd_x, rd_y, pix_valid, pix_data, pix_x, pix_y, pix_last,
               busy, done, hit
    );
endinterface

// File: rtl/rect_reader_fifo.sv
// Two-entry FIFO holding returned pixels; count feeds the read-credit check.
module rect_reader_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rp_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/rect_reader.sv
// Raster-scans a rectangle, reads the framebuffer and streams pixels out,
// flagging any pixel that differs from the background colour.
module rect_reader
    import rect_reader_pkg::*;
#(
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int BG_COLOR = BG_COLOR_DEF
) (
    input  logic          clk,
    input  logic          reset,
    rect_reader_if.slave  bus
);
    localparam int FW = 2 * COORD_W + 1 + COLOR_W;
    typedef logic [COORD_W-1:0] coord_t;

    state_e state_q, state_d;
    coord_t sx_q, sx_d, sy_q, sy_d, w_q, w_d, h_q, h_d;
    coord_t dx_q, dx_d, dy_q, dy_d;
    coord_t rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic   rd_en_q, rd_en_d, rd_last_q, rd_last_d;
    logic   busy_q, busy_d, done_q, done_d, hit_q, hit_d;

    // Read-return stage: aligned with rd_data one cycle after rd_en
    logic   vld1_q, last1_q;
    coord_t x1_q, y1_q;

    logic [FW-1:0]      head;
    logic [1:0]         fifo_cnt;
    coord_t             hx, hy;
    logic               hlast;
    logic [COLOR_W-1:0] hcol;
    logic               pix_valid, pop, can_issue, last_rd;
    logic [2:0]         outstanding;

    rect_reader_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (vld1_q),
        .data_i  ({x1_q, y1_q, last1_q, bus.rd_data}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

    assign {hx, hy, hlast, hcol} = head;
    assign pix_valid   = (fifo_cnt != 2'd0);
    assign pop         = pix_valid & bus.pix_ready;
    // Every issued read already owns a FIFO slot, so a push never meets a full FIFO
    assign outstanding = 3'(fifo_cnt) + 3'(rd_en_q) + 3'(vld1_q);
    assign can_issue   = (state_q == SCAN) && (outstanding < 3'd2);
    assign last_rd     = (dx_q == w_q - 8'd1) && (dy_q == h_q - 8'd1);

    always_comb begin
        state_d   = state_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        w_d       = w_q;
        h_d       = h_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        rd_en_d   = 1'b0;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        rd_last_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hit_d     = hit_q;
        if (vld1_q && (bus.rd_data != COLOR_W'(BG_COLOR))) hit_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sx_d    = bus.start_x;
                    sy_d    = bus.start_y;
                    w_d     = bus.width;
                    h_d     = bus.height;
                    dx_d    = '0;
                    dy_d    = '0;
                    hit_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (bus.width == '0 || bus.height == '0) ? EMPTY : SCAN;
                end
            end
            EMPTY: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            SCAN: begin
                if (can_issue) begin
                    rd_en_d   = 1'b1;
                    rd_x_d    = sx_q + dx_q;
                    rd_y_d    = sy_q + dy_q;
                    rd_last_d = last_rd;
                    if (last_rd) begin
                        state_d = DRAIN;
                    end else if (dx_q == w_q - 8'd1) begin
                        dx_d = '0;
                        dy_d = dy_q + 8'd1;
                    end else begin
                        dx_d = dx_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                // Stay one extra cycle so done is seen with busy still high
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (pop && hlast) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            rd_en_q   <= 1'b0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            vld1_q    <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            last1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            w_q       <= w_d;
            h_q       <= h_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            rd_en_q   <= rd_en_d;
            rd_x_q    <= rd_x_d;
            rd_y_q    <= rd_y_d;
            rd_last_q <= rd_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            vld1_q    <= rd_en_q;
            x1_q      <= rd_x_q;
            y1_q      <= rd_y_q;
            last1_q   <= rd_last_q;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_x      = rd_x_q;
    assign bus.rd_y      = rd_y_q;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = hcol;
    assign bus.pix_x     = hx;
    assign bus.pix_y     = hy;
    assign bus.pix_last  = hlast & pix_valid;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_rect_reader.sv
// Directed bench for rect_reader with a behavioural framebuffer RAM.
module tb_rect_reader;
    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mode   = 0;
    logic [7:0] hit_x = 8'd0;
    logic [7:0] hit_y = 8'd0;

    rect_reader_if #(.COLOR_W(3)) bus ();

    rect_reader #(.COLOR_W(3), .BG_COLOR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: 0 -> x^y, 1 -> single coloured pixel, 2 -> all background
    function automatic logic [2:0] ram_val(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] t;
        t = x ^ y;
        if (mode == 0) return t[2:0];
        if (mode == 1) return (x == hit_x && y == hit_y) ? 3'd5 : 3'd0;
        return 3'd0;
    endfunction

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram_val(bus.rd_x, bus.rd_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] w,
                        input logic [7:0] h, input int rmode, input int exp_first, input bit poke);
        int cyc, idx, issued, acc, first_v, last_acc, total;
        bit done_seen, stalled, exp_hit;
        logic [7:0] ex, ey, px, py;
        logic [2:0] pd;
        logic pl;
        total = int'(w) * int'(h);
        exp_hit = 1'b0;
        for (int j = 0; j < int'(h); j++)
            for (int i = 0; i < int'(w); i++)
                if (ram_val(sx + 8'(i), sy + 8'(j)) != 3'd0) exp_hit = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.start_x = sx; bus.start_y = sy; bus.width = w; bus.height = h;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("no_rd_cycle0", 32'(bus.rd_en), 32'd0);
        cyc = 0; idx = 0; issued = 0; acc = 0; first_v = -1; last_acc = -100;
        done_seen = 1'b0; stalled = 1'b0;
        px = '0; py = '0; pd = '0; pl = 1'b0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin
                bus.start = 1'b1; bus.start_x = 8'd0; bus.start_y = 8'd0;
                bus.width = 8'd1; bus.height = 8'd1;
            end else if (poke && cyc == 3) begin
                bus.start = 1'b0;
            end
            if (stalled) begin
                chk("stall_valid", 32'(bus.pix_valid), 32'd1);
                chk("stall_xy", {16'd0, bus.pix_x, bus.pix_y}, {16'd0, px, py});
                chk("stall_data", {28'd0, bus.pix_last, bus.pix_data}, {28'd0, pl, pd});
            end
            if (bus.rd_en) begin
                issued++;
                chk("credit", 32'(issued - acc <= 2), 32'd1);
            end
            bus.pix_ready = (rmode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
            if (bus.pix_valid && first_v < 0) first_v = cyc;
            stalled = 1'b0;
            if (bus.pix_valid) begin
                if (bus.pix_ready) begin
                    ex = sx + 8'(idx % int'(w));
                    ey = sy + 8'(idx / int'(w));
                    chk("pix_x", 32'(bus.pix_x), 32'(ex));
                    chk("pix_y", 32'(bus.pix_y), 32'(ey));
                    chk("pix_data", 32'(bus.pix_data), 32'(ram_val(ex, ey)));
                    chk("pix_last", 32'(bus.pix_last), 32'(idx == total - 1));
                    idx++; acc++; last_acc = cyc;
                end else begin
                    stalled = 1'b1;
                    px = bus.pix_x; py = bus.pix_y; pd = bus.pix_data; pl = bus.pix_last;
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                chk("done_count", 32'(idx), 32'(total));
                chk("done_latency", 32'(cyc), 32'(last_acc + 1));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
                chk("hit", 32'(bus.hit), 32'(exp_hit));
            end
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        if (exp_first >= 0) chk("first_valid_cycle", 32'(first_v), 32'(exp_first));
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_valid", 32'(bus.pix_valid), 32'd0);
        chk("hit_hold", 32'(bus.hit), 32'(exp_hit));
        bus.pix_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.start_x = '0; bus.start_y = '0;
        bus.width = '0; bus.height = '0; bus.pix_ready = 1'b1; bus.rd_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {27'd0, bus.rd_en, bus.pix_valid, bus.busy, bus.done, bus.hit}, 32'd0);
        chk("reset_xy", {bus.rd_x, bus.rd_y, bus.pix_x, bus.pix_y}, 32'd0);
        chk("reset_pix", {28'd0, bus.pix_last, bus.pix_data}, 32'd0);
        reset = 1'b0;

        // Basic scan with full acceptance
        mode = 0;
        scan(8'd10, 8'd20, 8'd3, 8'd2, 0, 3, 1'b0);

        // Backpressure 1,0,0 pattern
        scan(8'd5, 8'd7, 8'd4, 8'd1, 1, -1, 1'b0);

        // Empty rectangle: done two cycles after the start pulse
        @(negedge clk);
        bus.start = 1'b1; bus.start_x = 8'd3; bus.start_y = 8'd3; bus.width = 8'd0; bus.height = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("empty_c0_done", 32'(bus.done), 32'd0);
        chk("empty_c0_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("empty_c1_done", 32'(bus.done), 32'd1);
        chk("empty_c1_busy", 32'(bus.busy), 32'd0);
        chk("empty_hit", 32'(bus.hit), 32'd0);
        chk("empty_no_rd", {30'd0, bus.rd_en, bus.pix_valid}, 32'd0);
        @(negedge clk);
        chk("empty_c2_done", 32'(bus.done), 32'd0);
        chk("empty_c2_quiet", {30'd0, bus.rd_en, bus.pix_valid}, 32'd0);

        // Hit detect, then the same rectangle with background only
        mode = 1; hit_x = 8'd41; hit_y = 8'd51;
        scan(8'd40, 8'd50, 8'd2, 8'd2, 0, -1, 1'b0);
        mode = 2;
        scan(8'd40, 8'd50, 8'd2, 8'd2, 0, -1, 1'b0);

        // Coordinate wrap with a start pulse that must be ignored
        mode = 0;
        scan(8'd254, 8'd255, 8'd3, 8'd2, 1, -1, 1'b1);

        // Reset in the middle of a scan
        @(negedge clk);
        bus.start = 1'b1; bus.start_x = 8'd100; bus.start_y = 8'd90; bus.width = 8'd5; bus.height = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ctl", {27'd0, bus.rd_en, bus.pix_valid, bus.busy, bus.done, bus.hit}, 32'd0);
        chk("midrst_xy", {bus.rd_x, bus.rd_y, bus.pix_x, bus.pix_y}, 32'd0);
        chk("midrst_pix", {28'd0, bus.pix_last, bus.pix_data}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        scan(8'd10, 8'd20, 8'd3, 8'd2, 0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
